pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register replacing fixed-format inter-stage latches. It carries an opaque DATA_W-bit bundle (PC, instruction, operands, control) between two pipeline stages using a valid/ready handshake. A two-entry skid buffer keeps `in_ready` fully registered. Flush drives a programmable bubble value and counts discarded entries for performance monitoring.

---
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 tb/tb_pipe_stage_skid.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with a two-entry skid buffer, flush and drop counter
module pipe_stage_skid #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, pop;
  logic [CNT_W+1:0]  drop_sum;
  logic [CNT_W+1:0]  drop_max;
  logic [CNT_W-1:0]  drop_next;

  assign out_valid = (state != EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE_VAL;
  assign occupancy = state;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready & ~stall & ~flush;

  always_comb begin
    next_state = state;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      next_state = EMPTY;
      main_d     = BUBBLE_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state = ONE;
            main_d     = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            next_state = FULL;
            skid_d     = in_data;
          end else if (pop) begin
            next_state = EMPTY;
            main_d     = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (pop) begin
            next_state = ONE;
            main_d     = skid_q;
          end
        end
        default: begin
          next_state = EMPTY;
          main_d     = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Entries lost on flush: everything buffered plus the one offered this cycle.
  always_comb begin
    drop_max  = {2'b00, {CNT_W{1'b1}}};
    drop_sum  = {2'b00, drop_cnt} + {{CNT_W{1'b0}}, occupancy}
              + {{(CNT_W+1){1'b0}}, (in_valid & in_ready)};
    drop_next = (drop_sum > drop_max) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      main_q   <= BUBBLE_VAL;
      skid_q   <= BUBBLE_VAL;
      in_ready <= 1'b1;
      drop_cnt <= '0;
    end else begin
      state    <= next_state;
      main_q   <= main_d;
      skid_q   <= skid_d;
      in_ready <= (next_state != FULL);
      if (flush) begin
        drop_cnt <= drop_next;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

  localparam int          DATA_W = 16;
  localparam logic [15:0] BUBBLE = 16'hF000;
  localparam int          CNT_W  = 2;
  localparam int          CNT_MAX = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] mq[$];
  int                mcnt = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUBBLE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall    (stall),
    .flush    (flush),
    .occupancy(occupancy),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; acceptance is allowed whenever fewer than two are held.
  task automatic model_edge();
    int room;
    int dropped;
    room = (mq.size() < 2) ? 1 : 0;
    if (!reset_n) begin
      mq.delete();
      mcnt = 0;
    end else if (flush) begin
      dropped = mq.size() + ((in_valid && room == 1) ? 1 : 0);
      mcnt = (mcnt + dropped > CNT_MAX) ? CNT_MAX : mcnt + dropped;
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready && !stall) void'(mq.pop_front());
      if (in_valid && room == 1) mq.push_back(in_data);
    end
  endtask

  task automatic compare_model();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : BUBBLE));
    check("occupancy", 32'(occupancy), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check("drop_cnt", 32'(drop_cnt), 32'(mcnt));
  endtask

  task automatic step(input logic iv, input logic [15:0] id, input logic ordy,
                      input logic st, input logic fl, input logic rn);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    reset_n   = rn;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    step(1, 16'h1234, 1, 1, 1, 0);
    step(0, 16'h0000, 0, 0, 0, 0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'hF000);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming at full rate
    step(1, 16'h1111, 1, 0, 0, 1);
    check("stream0", 32'(out_data), 32'h1111);
    step(1, 16'h2222, 1, 0, 0, 1);
    check("stream1", 32'(out_data), 32'h2222);
    step(1, 16'h3333, 1, 0, 0, 1);
    check("stream2", 32'(out_data), 32'h3333);
    step(0, 16'h0000, 1, 0, 0, 1);
    check("stream_idle", 32'(out_data), 32'hF000);

    // Backpressure fills the skid entry
    step(1, 16'h00A1, 0, 0, 0, 1);
    check("bp_occ1", 32'(occupancy), 32'd1);
    check("bp_head", 32'(out_data), 32'h00A1);
    step(1, 16'h00A2, 0, 0, 0, 1);
    check("bp_occ2", 32'(occupancy), 32'd2);
    check("bp_ready0", 32'(in_ready), 32'd0);
    step(1, 16'h00A3, 0, 0, 0, 1);
    check("bp_hold", 32'(occupancy), 32'd2);
    step(1, 16'h00A3, 1, 0, 0, 1);
    check("bp_out_a2", 32'(out_data), 32'h00A2);
    check("bp_ready1", 32'(in_ready), 32'd1);
    step(1, 16'h00A3, 1, 0, 0, 1);
    check("bp_out_a3", 32'(out_data), 32'h00A3);
    step(0, 16'h0000, 1, 0, 0, 1);
    check("bp_drain", 32'(out_valid), 32'd0);

    // Stall overrides out_ready
    step(1, 16'h0055, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 16'h0000, 1, 1, 0, 1);
      check("stall_hold", 32'(out_data), 32'h0055);
    end
    step(0, 16'h0000, 1, 0, 0, 1);
    check("stall_pop", 32'(out_valid), 32'd0);

    // Flush in FULL with input offered but not ready
    step(1, 16'h00B1, 0, 0, 0, 1);
    step(1, 16'h00B2, 0, 0, 0, 1);
    step(1, 16'h00B3, 1, 0, 1, 1);
    check("flf_valid", 32'(out_valid), 32'd0);
    check("flf_data", 32'(out_data), 32'hF000);
    check("flf_occ", 32'(occupancy), 32'd0);
    check("flf_drop", 32'(drop_cnt), 32'd2);
    check("flf_ready", 32'(in_ready), 32'd1);

    // Flush in ONE with an accepted-looking input
    step(0, 16'h0000, 0, 0, 0, 0);
    step(1, 16'h00C1, 0, 0, 0, 1);
    step(1, 16'h00C2, 1, 0, 1, 1);
    check("flo_drop", 32'(drop_cnt), 32'd2);
    step(0, 16'h0000, 1, 0, 0, 1);
    check("flo_no_out", 32'(out_valid), 32'd0);

    // Saturation
    step(1, 16'h00D1, 0, 0, 1, 1);
    check("sat3", 32'(drop_cnt), 32'd3);
    step(1, 16'h00D2, 0, 0, 1, 1);
    check("sat_hold", 32'(drop_cnt), 32'd3);

    // Reset mid-FULL, flush asserted too
    step(1, 16'h00E1, 0, 0, 0, 1);
    step(1, 16'h00E2, 0, 0, 0, 1);
    step(1, 16'h00E3, 1, 0, 1, 0);
    check("rstf_occ", 32'(occupancy), 32'd0);
    check("rstf_drop", 32'(drop_cnt), 32'd0);
    check("rstf_valid", 32'(out_valid), 32'd0);
    check("rstf_ready", 32'(in_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
